// File: rtl/decode_stage.sv
// Registered RV32I decode stage with a two-entry (main + skid) output buffer.
// Define DECODE_RV32M_EN to decode the RV32M multiply/divide encodings of OP.
module decode_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_imm,
  output logic [2:0]        out_itype,
  output logic [4:0]        out_aluop,
  output logic              out_rfwe,
  output logic              out_dmwe,
  output logic              out_illegal
);

  typedef enum logic [2:0] {
    TyR   = 3'd0,
    TyI   = 3'd1,
    TyS   = 3'd2,
    TyB   = 3'd3,
    TyU   = 3'd4,
    TyJ   = 3'd5,
    TyBad = 3'd7
  } itype_e;

  localparam logic [4:0] AluAdd   = 5'd0;
  localparam logic [4:0] AluSub   = 5'd1;
  localparam logic [4:0] AluSll   = 5'd2;
  localparam logic [4:0] AluSlt   = 5'd3;
  localparam logic [4:0] AluSltu  = 5'd4;
  localparam logic [4:0] AluXor   = 5'd5;
  localparam logic [4:0] AluSrl   = 5'd6;
  localparam logic [4:0] AluSra   = 5'd7;
  localparam logic [4:0] AluOr    = 5'd8;
  localparam logic [4:0] AluAnd   = 5'd9;
  localparam logic [4:0] AluPassB = 5'd31;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    logic [2:0]        itype;
    logic [4:0]        aluop;
    logic              rfwe;
    logic              dmwe;
    logic              illegal;
  } bundle_t;

  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  itype_e      w_type;
  logic [4:0]  w_alu;
  logic        w_wr;
  logic        w_st;
  logic        w_bad;
  logic [31:0] w_imm32;
  bundle_t     w_dec;
  logic        w_accept;

  bundle_t     r_main;
  bundle_t     r_skid;
  logic        r_main_valid;
  logic        r_skid_valid;

  assign w_f3 = in_inst[14:12];
  assign w_f7 = in_inst[31:25];

  // Register-register / register-immediate funct3 mapping (base encoding, funct7 = 0).
  function automatic logic [4:0] f3_alu(input logic [2:0] f3);
    logic [4:0] alu;
    case (f3)
      3'd0:    alu = AluAdd;
      3'd1:    alu = AluSll;
      3'd2:    alu = AluSlt;
      3'd3:    alu = AluSltu;
      3'd4:    alu = AluXor;
      3'd5:    alu = AluSrl;
      3'd6:    alu = AluOr;
      default: alu = AluAnd;
    endcase
    return alu;
  endfunction

  always_comb begin
    w_type = TyR;
    w_alu  = AluAdd;
    w_wr   = 1'b0;
    w_st   = 1'b0;
    w_bad  = (in_inst[1:0] != 2'b11);
    case (in_inst[6:2])
      5'b01101: begin w_type = TyU; w_alu = AluPassB; w_wr = 1'b1; end  // LUI
      5'b00101: begin w_type = TyU; w_wr = 1'b1; end                    // AUIPC
      5'b11011: begin w_type = TyJ; w_wr = 1'b1; end                    // JAL
      5'b11001: begin w_type = TyI; w_wr = 1'b1; w_bad = w_bad | (w_f3 != 3'd0); end
      5'b11000: begin
        w_type = TyB;
        case (w_f3[2:1])
          2'b00:   w_alu = AluSub;
          2'b10:   w_alu = AluSlt;
          2'b11:   w_alu = AluSltu;
          default: w_bad = 1'b1;
        endcase
      end
      5'b00000: begin
        w_type = TyI;
        w_wr   = 1'b1;
        w_bad  = w_bad | (w_f3 == 3'd3) | (w_f3 == 3'd6) | (w_f3 == 3'd7);
      end
      5'b01000: begin w_type = TyS; w_st = 1'b1; w_bad = w_bad | w_f3[2] | (w_f3 == 3'd3); end
      5'b00100: begin
        w_type = TyI;
        w_wr   = 1'b1;
        w_alu  = f3_alu(w_f3);
        if (w_f3 == 3'd1) begin
          w_bad = w_bad | (w_f7 != 7'h00);
        end else if (w_f3 == 3'd5) begin
          if (w_f7 == 7'h20) w_alu = AluSra;
          else               w_bad = w_bad | (w_f7 != 7'h00);
        end
      end
      5'b01100: begin
        w_type = TyR;
        w_wr   = 1'b1;
        if (w_f7 == 7'h00) begin
          w_alu = f3_alu(w_f3);
        end else if (w_f7 == 7'h20 && w_f3 == 3'd0) begin
          w_alu = AluSub;
        end else if (w_f7 == 7'h20 && w_f3 == 3'd5) begin
          w_alu = AluSra;
        end else if (w_f7 == 7'h01) begin
`ifdef DECODE_RV32M_EN
          w_alu = 5'd10 + {2'b00, w_f3};
`else
          w_bad = 1'b1;
`endif
        end else begin
          w_bad = 1'b1;
        end
      end
      5'b00011: begin w_type = TyI; w_bad = w_bad | (w_f3 != 3'd0); end  // FENCE as nop
      default:  w_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_imm32 = '0;
    case (w_type)
      TyI:     w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
      TyS:     w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      TyB:     w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                          in_inst[11:8], 1'b0};
      TyU:     w_imm32 = {in_inst[31:12], 12'b0};
      TyJ:     w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                          in_inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  always_comb begin
    w_dec     = '0;
    w_dec.pc  = in_pc;
    w_dec.rs1 = REG_AW'(in_inst[19:15]);
    w_dec.rs2 = REG_AW'(in_inst[24:20]);
    w_dec.rd  = REG_AW'(in_inst[11:7]);
    if (w_bad) begin
      w_dec.itype   = TyBad;
      w_dec.illegal = 1'b1;
    end else begin
      w_dec.itype = w_type;
      w_dec.aluop = w_alu;
      w_dec.imm   = XLEN'($signed(w_imm32));
      w_dec.rfwe  = w_wr & (in_inst[11:7] != 5'd0);
      w_dec.dmwe  = w_st;
    end
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
      r_skid       <= '0;
    end else if (flush_i) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_main_valid || out_ready) begin
      // Main is free this edge: refill from skid first to keep FIFO order.
      if (r_skid_valid) begin
        r_main       <= r_skid;
        r_main_valid <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_main_valid <= w_accept;
        if (w_accept) r_main <= w_dec;
      end
    end else if (w_accept) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  assign in_ready    = ~r_skid_valid;
  assign out_valid   = r_main_valid;
  assign out_pc      = r_main.pc;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_rd      = r_main.rd;
  assign out_imm     = r_main.imm;
  assign out_itype   = r_main.itype;
  assign out_aluop   = r_main.aluop;
  assign out_rfwe    = r_main.rfwe;
  assign out_dmwe    = r_main.dmwe;
  assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed cases plus randomized traffic against a
// queue-based reference. Honours DECODE_RV32M_EN for the RV32M expectations.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  itype;
    logic [4:0]  aluop;
    logic        rfwe;
    logic        dmwe;
    logic        illegal;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [31:0] out_imm;
  logic [2:0]  out_itype;
  logic [4:0]  out_aluop;
  logic        out_rfwe;
  logic        out_dmwe;
  logic        out_illegal;

  exp_t        obs;
  exp_t        m_q[$];
  bit          m_zero;
  int          n_checks;
  int          n_errors;

  decode_stage #(
    .XLEN  (32),
    .REG_AW(5)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_rs1    (out_rs1),
    .out_rs2    (out_rs2),
    .out_rd     (out_rd),
    .out_imm    (out_imm),
    .out_itype  (out_itype),
    .out_aluop  (out_aluop),
    .out_rfwe   (out_rfwe),
    .out_dmwe   (out_dmwe),
    .out_illegal(out_illegal)
  );

  assign obs = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_itype, out_aluop,
                out_rfwe, out_dmwe, out_illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference decode from the ISA tables; immediates via signed shifts on a 32-bit int.
  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t       e;
    int         s;
    int         imm;
    int         t;
    int         alu;
    bit         wr;
    bit         st;
    bit         bad;
    logic [2:0] f3;
    logic [6:0] f7;
    int         base[8];
    int         br[8];
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    br   = '{1, 1, -1, -1, 3, 3, 4, 4};
    s  = int'(inst);
    f3 = inst[14:12];
    f7 = inst[31:25];
    t = 0; alu = 0; wr = 0; st = 0; bad = 0;
    case (inst[6:0])
      7'h37: begin t = 4; alu = 31; wr = 1; end
      7'h17: begin t = 4; wr = 1; end
      7'h6F: begin t = 5; wr = 1; end
      7'h67: begin t = 1; wr = 1; bad = (f3 != 0); end
      7'h63: begin t = 3; alu = br[f3]; bad = (alu < 0); end
      7'h03: begin t = 1; wr = 1; bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin t = 2; st = 1; bad = (f3 > 2); end
      7'h13: begin
        t = 1; wr = 1; alu = base[f3];
        if (f3 == 1) bad = (f7 != 0);
        if (f3 == 5) begin
          if (f7 == 7'h20) alu = 7;
          else bad = (f7 != 0);
        end
      end
      7'h33: begin
        t = 0; wr = 1;
        if (f7 == 0) alu = base[f3];
        else if (f7 == 7'h20 && f3 == 0) alu = 1;
        else if (f7 == 7'h20 && f3 == 5) alu = 7;
        else if (f7 == 7'h01) begin
`ifdef DECODE_RV32M_EN
          alu = 10 + int'(f3);
`else
          bad = 1;
`endif
        end else bad = 1;
      end
      7'h0F: begin t = 1; bad = (f3 != 0); end
      default: bad = 1;
    endcase
    case (t)
      1: imm = s >>> 20;
      2: imm = ((s >>> 25) << 5) | int'(inst[11:7]);
      3: imm = ((s >>> 31) << 12) | (int'(inst[7]) << 11) | (int'(inst[30:25]) << 5)
               | (int'(inst[11:8]) << 1);
      4: imm = s & 32'hFFFFF000;
      5: imm = ((s >>> 31) << 20) | (int'(inst[19:12]) << 12) | (int'(inst[20]) << 11)
               | (int'(inst[30:21]) << 1);
      default: imm = 0;
    endcase
    e     = '0;
    e.pc  = pc;
    e.rs1 = inst[19:15];
    e.rs2 = inst[24:20];
    e.rd  = inst[11:7];
    if (bad) begin
      e.itype   = 3'd7;
      e.illegal = 1'b1;
    end else begin
      e.itype = 3'(t);
      e.aluop = 5'(alu);
      e.imm   = 32'(imm);
      e.rfwe  = wr && (inst[11:7] != 0);
      e.dmwe  = st;
    end
    return e;
  endfunction

  task automatic model_edge();
    bit acc;
    bit fire;
    if (!rst_n) begin
      m_q.delete();
      m_zero = 1'b1;
    end else if (flush_i) begin
      m_q.delete();
    end else begin
      acc  = in_valid && (m_q.size() < 2);
      fire = (m_q.size() > 0) && out_ready;
      if (fire) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back(ref_decode(in_inst, in_pc));
        m_zero = 1'b0;
      end
    end
  endtask

  task automatic compare_outputs();
    check("in_ready", in_ready, m_q.size() < 2);
    check("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) check("bundle", obs, m_q[0]);
    else if (m_zero) check("reset_bundle", obs, '0);
  endtask

  // Drive at the falling edge, model the rising edge, sample at the next falling edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush_i   = fl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  ops[10];
    int          r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
    w = $urandom;
    r = $urandom_range(0, 15);
    if (r < 14) w[6:0] = ops[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  initial begin
    logic [31:0] pc;
    n_checks  = 0;
    n_errors  = 0;
    m_zero    = 1'b0;
    rst_n     = 1'b0;
    flush_i   = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    @(negedge clk);
    step(1'b1, 32'h0000_0013, 32'h10, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // addi x1,x0,-1
    step(1'b1, 32'hFFF0_0093, 32'h100, 1'b1, 1'b0);
    check("t1_itype", out_itype, 3'd1);
    check("t1_rd", out_rd, 5'd1);
    check("t1_rs1", out_rs1, 5'd0);
    check("t1_imm", out_imm, 32'hFFFF_FFFF);
    check("t1_aluop", out_aluop, 5'd0);
    check("t1_rfwe", out_rfwe, 1'b1);
    check("t1_dmwe", out_dmwe, 1'b0);

    // sw x2,8(x1) then jal x1,-4
    step(1'b1, 32'h0020_A423, 32'h104, 1'b1, 1'b0);
    check("t2_itype", out_itype, 3'd2);
    check("t2_rs1", out_rs1, 5'd1);
    check("t2_rs2", out_rs2, 5'd2);
    check("t2_imm", out_imm, 32'd8);
    check("t2_dmwe", out_dmwe, 1'b1);
    check("t2_rfwe", out_rfwe, 1'b0);
    step(1'b1, 32'hFFDF_F0EF, 32'h108, 1'b1, 1'b0);
    check("t2_jal_itype", out_itype, 3'd5);
    check("t2_jal_imm", out_imm, 32'hFFFF_FFFC);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: two accepted, third held off until release
    step(1'b1, 32'h0010_0113, 32'h200, 1'b0, 1'b0);
    step(1'b1, 32'h0020_0193, 32'h204, 1'b0, 1'b0);
    check("t3_ready_low", in_ready, 1'b0);
    step(1'b1, 32'h0030_0213, 32'h208, 1'b0, 1'b0);
    check("t3_hold_pc", out_pc, 32'h200);
    step(1'b1, 32'h0030_0213, 32'h208, 1'b1, 1'b0);
    check("t3_second_pc", out_pc, 32'h204);
    check("t3_ready_back", in_ready, 1'b1);
    step(1'b1, 32'h0030_0213, 32'h208, 1'b1, 1'b0);
    check("t3_third_pc", out_pc, 32'h208);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush with both entries full and a same-cycle offer
    step(1'b1, 32'h0050_0293, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h0060_0313, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h0070_0393, 32'h308, 1'b0, 1'b1);
    check("t4_valid", out_valid, 1'b0);
    check("t4_ready", in_ready, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // mul x3,x1,x2
    step(1'b1, 32'h0220_81B3, 32'h400, 1'b1, 1'b0);
`ifdef DECODE_RV32M_EN
    check("t5_aluop", out_aluop, 5'd10);
    check("t5_rfwe", out_rfwe, 1'b1);
    check("t5_rd", out_rd, 5'd3);
`else
    check("t5_illegal", out_illegal, 1'b1);
    check("t5_itype", out_itype, 3'd7);
    check("t5_rfwe", out_rfwe, 1'b0);
`endif

    // nop to x0, all-zero word, reset mid-stream
    step(1'b1, 32'h0000_0013, 32'h500, 1'b1, 1'b0);
    check("t6_nop_rfwe", out_rfwe, 1'b0);
    step(1'b1, 32'h0000_0000, 32'h504, 1'b1, 1'b0);
    check("t6_zero_illegal", out_illegal, 1'b1);
    check("t6_zero_rfwe", out_rfwe, 1'b0);
    step(1'b1, 32'h0010_0093, 32'h508, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 32'h0020_0093, 32'h50C, 1'b0, 1'b0);
    check("t6_rst_valid", out_valid, 1'b0);
    rst_n = 1'b1;

    // Randomized traffic
    pc = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      step($urandom_range(0, 3) != 0, rand_inst(), pc, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0);
      pc = pc + 32'd4;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
